// File: rtl/oagu_sorter_pkg.sv
// Shared types and helpers for the sorter output address generator.
// Line geometry, IOB address width, FSM encoding and count/mask helpers.
package oagu_sorter_pkg;
  localparam int LANES      = 32;
  localparam int DATA_W     = 16;
  localparam int IOB_ADDR_W = 12;
  localparam int CNT_W      = 12;
  localparam int NUM_W      = 16;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] line_t;
  typedef logic [LANES-1:0]             mask_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // Whole lines plus one partial line when the element count is not line-aligned.
  function automatic logic [CNT_W-1:0] line_count(input logic [NUM_W-1:0] num);
    return CNT_W'(num >> LANE_IDX_W) + CNT_W'(|num[LANE_IDX_W-1:0]);
  endfunction

  function automatic mask_t last_mask(input logic [LANE_IDX_W-1:0] rem);
    mask_t m;
    m = '1;
    if (rem != '0)
      for (int i = 0; i < LANES; i++) m[i] = (LANE_IDX_W'(i) < rem);
    return m;
  endfunction
endpackage

// File: rtl/oagu_sorter_if.sv
// Sorter-side handshake, controller start/status and IOB write port bundle.
interface oagu_sorter_if;
  import oagu_sorter_pkg::*;

  logic                  i_AGUStart;
  logic [IOB_ADDR_W-1:0] i_StartAddr;
  logic [NUM_W-1:0]      i_Output_sorter_num;
  logic                  i_sorter_valid;
  line_t                 i_sorter_data;
  logic                  o_sorter_ready;
  logic                  i_IOB_WGnt;
  logic                  o_IOB_WEn;
  logic [IOB_ADDR_W-1:0] o_IOB_WAddr;
  line_t                 o_IOB_WData;
  mask_t                 o_IOB_WMask;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_AGUStart, i_StartAddr, i_Output_sorter_num, i_sorter_valid, i_sorter_data, i_IOB_WGnt,
    output o_sorter_ready, o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_IOB_WMask, o_busy, o_done
  );

  modport master (
    output i_AGUStart, i_StartAddr, i_Output_sorter_num, i_sorter_valid, i_sorter_data, i_IOB_WGnt,
    input  o_sorter_ready, o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_IOB_WMask, o_busy, o_done
  );
endinterface

// File: rtl/oagu_sorter_line_fifo.sv
// Synchronous result-line FIFO with flush; head is read combinationally.
module oagu_line_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  logic [PW:0] wr_q, rd_q;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A pop frees the slot being written, so push is allowed on a full FIFO then.
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign rdata_o = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + ONE;
      if (do_pop)  rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/oagu_sorter.sv
// Write-side AGU: buffers sorted lines and writes them to consecutive IOB lines,
// masking the unused lanes of a partial final line.
module oagu_sorter
  import oagu_sorter_pkg::*;
#(
  parameter int WR_INTERVAL = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  oagu_sorter_if.slave    bus
);
  localparam logic [2:0] GAP_MIN = 3'(WR_INTERVAL - 1);

  state_e                state_q, state_d;
  logic [IOB_ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]      lines_q, acc_q, iss_q;
  mask_t                 lmask_q;
  logic [2:0]            gap_q;

  logic                  wen_q;
  logic [IOB_ADDR_W-1:0] waddr_q;
  line_t                 wdata_q;
  mask_t                 wmask_q;

  logic  start, run, ready, push, pop, fifo_full, fifo_empty, busy, done;
  line_t head;

  assign start = bus.i_AGUStart;
  assign run   = (state_q == ST_RUN);
  assign ready = run & ~fifo_full & (acc_q < lines_q) & ~start;
  assign push  = ready & bus.i_sorter_valid;
  // Start blocks issue so no line of an aborted job gets registered at the restart edge.
  assign pop   = run & ~fifo_empty & bus.i_IOB_WGnt & (gap_q >= GAP_MIN) & ~start;

  oagu_line_fifo #(.DEPTH(FIFO_DEPTH), .T(line_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .flush_i (start),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.i_sorter_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (iss_q == lines_q) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      lines_q <= '0;
      lmask_q <= '0;
      acc_q   <= '0;
      iss_q   <= '0;
      gap_q   <= '0;
    end else if (start) begin
      addr_q  <= bus.i_StartAddr;
      lines_q <= line_count(bus.i_Output_sorter_num);
      lmask_q <= last_mask(bus.i_Output_sorter_num[LANE_IDX_W-1:0]);
      acc_q   <= '0;
      iss_q   <= '0;
      gap_q   <= '0;
    end else begin
      if (push) acc_q <= acc_q + 1'b1;
      if (pop) begin
        iss_q  <= iss_q + 1'b1;
        addr_q <= addr_q + 1'b1;
        gap_q  <= '0;
      end else if (gap_q != 3'd7) begin
        gap_q  <= gap_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      wen_q <= pop;
      if (pop) begin
        waddr_q <= addr_q;
        wdata_q <= head;
        wmask_q <= (iss_q == lines_q - 1'b1) ? lmask_q : '1;
      end
    end
  end

  assign bus.o_sorter_ready = ready;
  assign bus.o_IOB_WEn      = wen_q;
  assign bus.o_IOB_WAddr    = waddr_q;
  assign bus.o_IOB_WData    = wdata_q;
  assign bus.o_IOB_WMask    = wmask_q;
  assign bus.o_busy         = busy;
  assign bus.o_done         = done;
endmodule

// File: tb/tb_oagu_sorter.sv
// Randomized bench for oagu_sorter: offered lines and job parameters drive a
// queue-based model of expected IOB writes (address, data, mask, count).
module tb_oagu_sorter;
  import oagu_sorter_pkg::*;
  localparam int CW = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oagu_sorter_if bif ();
  oagu_sorter_if bif2 ();

  oagu_sorter #(.WR_INTERVAL(1), .FIFO_DEPTH(4)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bif)
  );
  oagu_sorter #(.WR_INTERVAL(5), .FIFO_DEPTH(4)) dut_gap (
    .i_clk (clk), .i_rst (rst), .bus (bif2)
  );

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int acc_n = 0, done_n = 0, done2_n = 0, src_idx = 0, src2_idx = 0;
  bit src_en = 0, rnd_gnt = 0, rnd_vld = 0;
  line_t       src_q[$], src2_q[$], got_d[$], got2_d[$];
  logic [11:0] got_a[$], got2_a[$];
  mask_t       got_m[$];
  int          got_t[$], got2_t[$];

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LANES; i++) l[i] = DATA_W'($urandom);
    return l;
  endfunction

  // One clock: sample at negedge, then drive the sorter sources just after posedge.
  task automatic step();
    @(negedge clk);
    if (bif.i_sorter_valid && bif.o_sorter_ready) begin acc_n++; src_idx++; end
    if (bif.o_IOB_WEn) begin
      got_a.push_back(bif.o_IOB_WAddr); got_d.push_back(bif.o_IOB_WData);
      got_m.push_back(bif.o_IOB_WMask); got_t.push_back(cyc);
    end
    if (bif.o_done) begin done_n++; done_cyc = cyc; end
    if (bif2.i_sorter_valid && bif2.o_sorter_ready) src2_idx++;
    if (bif2.o_IOB_WEn) begin
      got2_a.push_back(bif2.o_IOB_WAddr); got2_d.push_back(bif2.o_IOB_WData); got2_t.push_back(cyc);
    end
    if (bif2.o_done) done2_n++;
    @(posedge clk);
    #1;
    cyc++;
    bif.i_sorter_valid = src_en && (src_idx < src_q.size()) && !(rnd_vld && $urandom_range(0, 2) == 0);
    bif.i_sorter_data  = (src_idx < src_q.size()) ? src_q[src_idx] : '0;
    if (rnd_gnt) bif.i_IOB_WGnt = ($urandom % 4) != 0;
    bif2.i_sorter_valid = (src2_idx < src2_q.size());
    bif2.i_sorter_data  = (src2_idx < src2_q.size()) ? src2_q[src2_idx] : '0;
  endtask

  task automatic clear_got();
    got_a.delete(); got_d.delete(); got_m.delete(); got_t.delete();
    done_n = 0;
  endtask

  // Valid is already high with line 0 in the start cycle: start must win.
  task automatic start_job(input logic [11:0] a, input logic [15:0] n, input int offered);
    src_q.delete();
    for (int k = 0; k < offered; k++) src_q.push_back(rand_line());
    src_idx = 0; acc_n = 0; src_en = 1;
    bif.i_sorter_valid = 1'b1;
    bif.i_sorter_data  = src_q[0];
    bif.i_StartAddr = a;
    bif.i_Output_sorter_num = n;
    bif.i_AGUStart = 1'b1;
    start_cyc = cyc;
    step();
    bif.i_AGUStart = 1'b0;
    chk("start_wins", acc_n, 0);
    clear_got();
  endtask

  task automatic finish_job(input logic [11:0] a, input logic [15:0] n, input int offered, input int maxc);
    int L, expacc, r;
    mask_t lm, em;
    L = (int'(n) + LANES - 1) / LANES;
    expacc = (offered < L) ? offered : L;
    for (int k = 0; k < maxc && done_n == 0; k++) step();
    chk("done_seen", done_n != 0, 1);
    repeat (3) step();
    chk("done_once", done_n, 1);
    chk("accepted", acc_n, expacc);
    chk("nwrites", got_a.size(), L);
    chk("busy_end", bif.o_busy, 0);
    r = int'(n) % LANES;
    lm = (r == 0) ? '1 : mask_t'((64'd1 << r) - 64'd1);
    for (int k = 0; k < got_a.size() && k < L; k++) begin
      em = (k == L - 1) ? lm : '1;
      chk($sformatf("addr%0d", k), got_a[k], (int'(a) + k) % 4096);
      chk($sformatf("data%0d", k), got_d[k], src_q[k]);
      chk($sformatf("mask%0d", k), got_m[k], em);
    end
  endtask

  initial begin
    bif.i_AGUStart = 0; bif.i_StartAddr = '0; bif.i_Output_sorter_num = '0;
    bif.i_sorter_valid = 0; bif.i_sorter_data = '0; bif.i_IOB_WGnt = 1;
    bif2.i_AGUStart = 0; bif2.i_StartAddr = '0; bif2.i_Output_sorter_num = '0;
    bif2.i_sorter_valid = 0; bif2.i_sorter_data = '0; bif2.i_IOB_WGnt = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", bif.o_IOB_WEn, 0);
    chk("rst_waddr", bif.o_IOB_WAddr, 0);
    chk("rst_wmask", bif.o_IOB_WMask, 0);
    chk("rst_wdata", bif.o_IOB_WData, 0);
    chk("rst_ready", bif.o_sorter_ready, 0);
    chk("rst_busy", bif.o_busy, 0);
    chk("rst_done", bif.o_done, 0);
    rst = 0;
    step();

    // two full lines, back-to-back
    start_job(12'h010, 16'd64, 4);
    chk("busy_run", bif.o_busy, 1);
    finish_job(12'h010, 16'd64, 4, 50);
    if (got_t.size() > 0) chk("latency", got_t[0] - start_cyc, 3);

    // partial last line; 4th offered line refused
    start_job(12'h2A0, 16'd70, 4);
    finish_job(12'h2A0, 16'd70, 4, 50);
    chk("ready_beyond", bif.o_sorter_ready, 0);

    // write grant stalled
    start_job(12'h080, 16'd256, 8);
    bif.i_IOB_WGnt = 0;
    repeat (20) step();
    chk("stall_acc", acc_n, 4);
    chk("stall_ready", bif.o_sorter_ready, 0);
    chk("stall_nowr", got_a.size(), 0);
    bif.i_IOB_WGnt = 1;
    finish_job(12'h080, 16'd256, 8, 100);

    // address wrap
    start_job(12'hFFE, 16'd96, 3);
    finish_job(12'hFFE, 16'd96, 3, 50);

    // zero count
    start_job(12'h123, 16'd0, 2);
    finish_job(12'h123, 16'd0, 2, 10);
    chk("zero_done_lat", done_cyc - start_cyc, 2);

    // write interval of 5
    src2_q.delete();
    for (int k = 0; k < 3; k++) src2_q.push_back(rand_line());
    src2_idx = 0; done2_n = 0;
    bif2.i_sorter_valid = 0;
    bif2.i_StartAddr = 12'h040; bif2.i_Output_sorter_num = 16'd96; bif2.i_AGUStart = 1;
    step();
    bif2.i_AGUStart = 0;
    got2_a.delete(); got2_d.delete(); got2_t.delete();
    for (int k = 0; k < 100 && done2_n == 0; k++) step();
    chk("gap_nwr", got2_a.size(), 3);
    for (int k = 0; k < got2_a.size() && k < 3; k++) begin
      chk($sformatf("gap_addr%0d", k), got2_a[k], 12'h040 + k);
      chk($sformatf("gap_data%0d", k), got2_d[k], src2_q[k]);
      if (k > 0) chk($sformatf("gap_dist%0d", k), got2_t[k] - got2_t[k-1], 5);
    end

    // restart mid-job with a full FIFO of old lines
    start_job(12'h100, 16'd256, 8);
    bif.i_IOB_WGnt = 0;
    repeat (6) step();
    chk("old_full_acc", acc_n, 4);
    bif.i_IOB_WGnt = 1;
    start_job(12'h200, 16'd64, 3);
    finish_job(12'h200, 16'd64, 3, 50);

    // randomized jobs with random grant and valid gaps
    rnd_gnt = 1; rnd_vld = 1;
    for (int j = 0; j < 5; j++) begin
      logic [11:0] a;
      logic [15:0] n;
      a = 12'($urandom);
      n = 16'($urandom_range(1, 200));
      start_job(a, n, (int'(n) + LANES - 1) / LANES + 1);
      finish_job(a, n, (int'(n) + LANES - 1) / LANES + 1, 2000);
    end
    rnd_gnt = 0; rnd_vld = 0; bif.i_IOB_WGnt = 1;

    // async reset mid-job
    start_job(12'h300, 16'd256, 8);
    repeat (5) step();
    chk("pre_rst_wen", bif.o_IOB_WEn, 1);
    #3 rst = 1;
    #1;
    chk("arst_wen", bif.o_IOB_WEn, 0);
    chk("arst_waddr", bif.o_IOB_WAddr, 0);
    chk("arst_wmask", bif.o_IOB_WMask, 0);
    chk("arst_wdata", bif.o_IOB_WData, 0);
    chk("arst_busy", bif.o_busy, 0);
    chk("arst_ready", bif.o_sorter_ready, 0);
    src_en = 0;
    step();
    rst = 0;
    clear_got();
    repeat (6) step();
    chk("post_rst_nowr", got_a.size(), 0);
    chk("post_rst_nodone", done_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
